fifo_stream_out: RTL and testbench

FIFO_STREAM_OUT -- requirements
Module: fifo_stream_out

---
 rtl/fifo_stream_out.sv | 162 ++++++++++++++++
 tb/tb_fifo_stream_out.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_out.sv
// ---------------------------------------------------------------------------
// fifo_stream_out
// Converts the two-cycle-latency read port of an upstream FIFO into a
// valid/ready stream. Pops are issued only when the skid buffer is sure to
// have room for every word still in flight, so under normal operation the
// buffer never overflows. The stream output is driven purely from registers.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   flush       synchronous flush; also forwarded to the upstream FIFO
//   fifo_empty  upstream empty flag
//   fifo_valid  upstream read data valid (two cycles after a pop)
//   fifo_rdata  upstream read data
//   fifo_pop    pop request to upstream
//   fifo_flush  flush to upstream (equals flush)
//   m_valid     stream valid (registered)
//   m_ready     stream ready
//   m_data      stream data (registered head entry)
//   occ         skid buffer occupancy
//   err         sticky overflow flag, cleared only by reset
// ---------------------------------------------------------------------------
module fifo_stream_out #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       fifo_empty,
    input  logic                       fifo_valid,
    input  logic [WIDTH-1:0]           fifo_rdata,
    output logic                       fifo_pop,
    output logic                       fifo_flush,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    output logic [$clog2(DEPTH):0]     occ,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW:0]   DEPTH_S = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];

    logic [PW-1:0]    wr_ptr_r, rd_ptr_r, occ_r, inflight_r;
    logic             m_valid_r, err_r;
    logic [WIDTH-1:0] m_data_r;

    logic [PW-1:0]    wr_ptr_s, rd_ptr_s, occ_s, inflight_s;
    logic             m_valid_s, err_s;
    logic [WIDTH-1:0] m_data_s;

    logic             pop_s, rd_en_s, wr_en_s, ovf_s, full_s;
    logic [PW:0]      committed_s;
    logic [AW-1:0]    head_idx_s;

    assign fifo_flush = flush;
    assign fifo_pop   = pop_s;
    assign m_valid    = m_valid_r;
    assign m_data     = m_data_r;
    assign occ        = occ_r;
    assign err        = err_r;

    // Pop request: only when buffered plus in-flight words leave a free slot.
    always_comb begin
        committed_s = {1'b0, occ_r} + {1'b0, inflight_r};
        if (rst_n && !fifo_empty && !flush && (committed_s < DEPTH_S)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Next-state computation for pointers, counters and registered outputs.
    always_comb begin
        full_s     = (occ_r == DEPTH_P);
        rd_en_s    = m_valid_r && m_ready && !flush;
        wr_en_s    = fifo_valid && !flush && (!full_s || rd_en_s);
        ovf_s      = fifo_valid && !flush && full_s && !rd_en_s;

        wr_ptr_s   = wr_ptr_r;
        rd_ptr_s   = rd_ptr_r;
        occ_s      = occ_r;
        inflight_s = inflight_r;
        m_valid_s  = m_valid_r;
        m_data_s   = m_data_r;
        err_s      = err_r | ovf_s;
        head_idx_s = rd_ptr_r[AW-1:0];

        if (flush) begin
            wr_ptr_s   = {PW{1'b0}};
            rd_ptr_s   = {PW{1'b0}};
            occ_s      = {PW{1'b0}};
            inflight_s = {PW{1'b0}};
            m_valid_s  = 1'b0;
        end else begin
            wr_ptr_s   = wr_ptr_r + PW'(wr_en_s);
            rd_ptr_s   = rd_ptr_r + PW'(rd_en_s);
            occ_s      = occ_r + PW'(wr_en_s) - PW'(rd_en_s);
            head_idx_s = rd_ptr_s[AW-1:0];
            m_valid_s  = (occ_s != {PW{1'b0}});

            // A valid with nothing outstanding cannot underflow the counter.
            case ({pop_s, fifo_valid})
                2'b10:   inflight_s = inflight_r + {{(PW-1){1'b0}}, 1'b1};
                2'b01: begin
                    if (inflight_r != {PW{1'b0}}) begin
                        inflight_s = inflight_r - {{(PW-1){1'b0}}, 1'b1};
                    end else begin
                        inflight_s = inflight_r;
                    end
                end
                default: inflight_s = inflight_r;
            endcase

            // The new head is the word being written this edge only when the
            // buffer is otherwise empty; then the slot index coincides.
            if (occ_s != {PW{1'b0}}) begin
                if (wr_en_s && (wr_ptr_r[AW-1:0] == head_idx_s)) begin
                    m_data_s = fifo_rdata;
                end else begin
                    m_data_s = mem_r[head_idx_s];
                end
            end else begin
                m_data_s = m_data_r;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            occ_r      <= {PW{1'b0}};
            inflight_r <= {PW{1'b0}};
            m_valid_r  <= 1'b0;
            m_data_r   <= {WIDTH{1'b0}};
            err_r      <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            occ_r      <= occ_s;
            inflight_r <= inflight_s;
            m_valid_r  <= m_valid_s;
            m_data_r   <= m_data_s;
            err_r      <= err_s;
        end
    end

    // Skid buffer storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= fifo_rdata;
        end
    end

endmodule

// File: tb/tb_fifo_stream_out.sv
module tb_fifo_stream_out;

    logic        clk = 1'b0;
    logic        rst_n, flush, fifo_empty, fifo_valid, fifo_pop, fifo_flush;
    logic        m_valid, m_ready, err;
    logic [15:0] fifo_rdata, m_data;
    logic [2:0]  occ;

    fifo_stream_out #(.WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .fifo_empty(fifo_empty),
        .fifo_valid(fifo_valid), .fifo_rdata(fifo_rdata), .fifo_pop(fifo_pop),
        .fifo_flush(fifo_flush), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .occ(occ), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fe, fv;
        logic [15:0] rdata;
        logic        mr, fl;
        logic        pop, ffl, mv;
        logic [15:0] md;
        logic [2:0]  occ;
        logic        err;
    } vec_t;

    vec_t vecs [21];

    int n_checks = 0;
    int n_fail   = 0;

    // upstream two-cycle FIFO model and output scoreboard
    logic [15:0] src_q [$];
    logic [15:0] exp_q [$];
    logic        p1v, p2v;
    logic [15:0] p1d, p2d;
    int cyc, pop_cnt, mv_cnt, first_pop, first_mv, run, max_run;

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic clear_model();
        src_q.delete();
        exp_q.delete();
        p1v = 1'b0; p2v = 1'b0; p1d = 16'h0; p2d = 16'h0;
        fifo_valid = 1'b0; fifo_rdata = 16'h0; fifo_empty = 1'b1;
        cyc = 0; pop_cnt = 0; mv_cnt = 0; first_pop = -1; first_mv = -1;
        run = 0; max_run = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // one clock of the upstream model plus scoreboard consumption
    task automatic step();
        logic pop_s, fl_s;
        #1;
        pop_s = fifo_pop;
        fl_s  = flush;
        if (m_valid) begin
            mv_cnt++;
            run++;
            if (run > max_run) max_run = run;
            if (first_mv < 0) first_mv = cyc;
        end else begin
            run = 0;
        end
        if (pop_s) begin
            pop_cnt++;
            if (first_pop < 0) first_pop = cyc;
        end
        if (m_valid && m_ready && !fl_s) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_extra: got word %0h, expected none", m_data);
            end else begin
                check("sb_data", {16'h0, m_data}, {16'h0, exp_q.pop_front()});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (fl_s) begin
            p1v = 1'b0; p2v = 1'b0;
            src_q.delete();
        end else begin
            p2v = p1v; p2d = p1d;
            p1v = pop_s;
            if (pop_s) p1d = src_q.pop_front();
        end
        fifo_valid = p2v;
        fifo_rdata = p2v ? p2d : 16'h0;
        fifo_empty = (src_q.size() == 0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 3'd1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 16'hA000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 3'd0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 16'hA001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA000, 3'd1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 16'hA002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA000, 3'd2, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 16'hA003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA000, 3'd3, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 16'hA004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA000, 3'd4, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA000, 3'd4, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA000, 3'd4, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 16'hA005, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA001, 3'd3, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA002, 3'd3, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'hA002, 3'd3, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA002, 3'd0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hA002, 3'd0, 1'b1};
        vecs[17] = '{1'b1, 1'b1, 16'hB000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA002, 3'd0, 1'b1};
        vecs[18] = '{1'b1, 1'b1, 16'hB001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hB000, 3'd1, 1'b1};
        vecs[19] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hB001, 3'd1, 1'b1};
        vecs[20] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hB001, 3'd1, 1'b1};

        // ---- table: pins driven directly, one row per cycle ----
        do_reset();
        for (int i = 0; i < 21; i++) begin
            fifo_empty = vecs[i].fe;
            fifo_valid = vecs[i].fv;
            fifo_rdata = vecs[i].rdata;
            m_ready    = vecs[i].mr;
            flush      = vecs[i].fl;
            #1;
            check($sformatf("v%0d_pop", i),  {31'h0, fifo_pop},   {31'h0, vecs[i].pop});
            check($sformatf("v%0d_ffl", i),  {31'h0, fifo_flush}, {31'h0, vecs[i].ffl});
            check($sformatf("v%0d_mv", i),   {31'h0, m_valid},    {31'h0, vecs[i].mv});
            check($sformatf("v%0d_md", i),   {16'h0, m_data},     {16'h0, vecs[i].md});
            check($sformatf("v%0d_occ", i),  {29'h0, occ},        {29'h0, vecs[i].occ});
            check($sformatf("v%0d_err", i),  {31'h0, err},        {31'h0, vecs[i].err});
            @(posedge clk);
            #1;
        end
        flush = 1'b0;

        // ---- single word latency ----
        do_reset();
        check("rst_mv", {31'h0, m_valid}, 32'h0);
        check("rst_occ", {29'h0, occ}, 32'h0);
        src_q.push_back(16'h1234);
        exp_q.push_back(16'h1234);
        fifo_empty = 1'b0;
        m_ready = 1'b1;
        repeat (8) step();
        check("sw_pops", pop_cnt, 1);
        check("sw_latency", first_mv - first_pop, 3);
        check("sw_mv_cycles", mv_cnt, 1);
        check("sw_left", exp_q.size(), 0);

        // ---- streaming 16 words ----
        do_reset();
        for (int i = 0; i < 16; i++) begin
            src_q.push_back(16'(i));
            exp_q.push_back(16'(i));
        end
        fifo_empty = 1'b0;
        m_ready = 1'b1;
        repeat (25) step();
        check("st_latency", first_mv - first_pop, 3);
        check("st_run", max_run, 16);
        check("st_mv_cycles", mv_cnt, 16);
        check("st_left", exp_q.size(), 0);

        // ---- backpressure ----
        do_reset();
        for (int i = 0; i < 8; i++) begin
            src_q.push_back(16'h0100 + 16'(i));
            exp_q.push_back(16'h0100 + 16'(i));
        end
        fifo_empty = 1'b0;
        m_ready = 1'b0;
        repeat (10) step();
        check("bp_occ", {29'h0, occ}, 32'd4);
        check("bp_pop", {31'h0, fifo_pop}, 32'h0);
        check("bp_pops", pop_cnt, 4);
        check("bp_err", {31'h0, err}, 32'h0);
        check("bp_head", {16'h0, m_data}, 32'h0100);
        m_ready = 1'b1;
        repeat (20) step();
        check("bp_left", exp_q.size(), 0);
        check("bp_pops_all", pop_cnt, 8);
        check("bp_err_end", {31'h0, err}, 32'h0);

        // ---- flush mid-stream ----
        do_reset();
        for (int i = 0; i < 8; i++) src_q.push_back(16'h0300 + 16'(i));
        fifo_empty = 1'b0;
        m_ready = 1'b0;
        repeat (4) step();
        check("fl_occ_pre", {29'h0, occ}, 32'd2);
        check("fl_valid_in", {31'h0, fifo_valid}, 32'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_occ", {29'h0, occ}, 32'h0);
        check("fl_mv", {31'h0, m_valid}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            src_q.push_back(16'h0400 + 16'(i));
            exp_q.push_back(16'h0400 + 16'(i));
        end
        fifo_empty = 1'b0;
        m_ready = 1'b1;
        step();
        check("fl_mv_after", {31'h0, m_valid}, 32'h0);
        repeat (10) step();
        check("fl_left", exp_q.size(), 0);
        check("fl_err", {31'h0, err}, 32'h0);

        // ---- reset mid-stream ----
        do_reset();
        for (int i = 0; i < 4; i++) src_q.push_back(16'h0500 + 16'(i));
        fifo_empty = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (occ == 3'd2) break;
            step();
        end
        check("rm_occ_pre", {29'h0, occ}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("rm_mv", {31'h0, m_valid}, 32'h0);
        check("rm_occ", {29'h0, occ}, 32'h0);
        check("rm_err", {31'h0, err}, 32'h0);
        check("rm_pop", {31'h0, fifo_pop}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_model();
        src_q.push_back(16'h0600);
        exp_q.push_back(16'h0600);
        fifo_empty = 1'b0;
        m_ready = 1'b1;
        repeat (8) step();
        check("rm_left", exp_q.size(), 0);
        check("rm_mv_cycles", mv_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
